// File: rtl/dmem_pipe_ctrl.sv
// Synchronous data memory with ready/valid requests, byte lanes,
// configurable read latency, error reporting and a post-reset init sweep.
module dmem_pipe_ctrl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 1,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              init_done
);

  localparam int NB = DATA_W / 8;
  localparam int B  = $clog2(NB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] AMASK = ADDR_W'((1 << B) - 1);

  if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_lat
    $error("dmem_pipe_ctrl: RD_LAT must be 1..4");
  end
  if (DATA_W % 8 != 0 || DATA_W < 8) begin : g_bad_w
    $error("dmem_pipe_ctrl: DATA_W must be a multiple of 8");
  end

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   init_ptr_q, init_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              vld_q [RD_LAT];
  logic              err_q [RD_LAT];
  logic [DATA_W-1:0] dat_q [RD_LAT];
  logic              vld_d, err_d;
  logic [DATA_W-1:0] dat_d;

  logic              acc, misal, oor, err;
  logic [ADDR_W-1:0] idx_full;
  logic [IW-1:0]     idx;

  assign idx_full = req_addr >> B;
  assign idx      = idx_full[IW-1:0];
  assign misal    = |(req_addr & AMASK);
  assign oor      = idx_full >= ADDR_W'(DEPTH);
  assign err      = misal | oor;
  assign acc      = req_valid & req_ready;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= S_INIT;
      init_ptr_q <= '0;
    end else begin
      state_q    <= state_d;
      init_ptr_q <= init_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_ptr_d = init_ptr_q;
    unique case (state_q)
      S_INIT: begin
        init_ptr_d = init_ptr_q + 1'b1;
        if (init_ptr_q == IW'(DEPTH - 1)) state_d = S_RUN;
      end
      S_RUN: state_d = S_RUN;
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    req_ready = (state_q == S_RUN);
    init_done = (state_q == S_RUN);
  end

  // Array has no reset; the init sweep defines its contents.
  always_ff @(posedge clock) begin
    if (state_q == S_INIT) begin
      mem_q[init_ptr_q] <= INIT_VAL;
    end else if (acc && req_we && !err) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    vld_d = acc;
    err_d = acc & err;
    dat_d = '0;
    if (acc && !req_we && !err) dat_d = mem_q[idx];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        vld_q[i] <= 1'b0;
        err_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= vld_d;
      err_q[0] <= err_d;
      dat_q[0] <= dat_d;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        err_q[i] <= err_q[i-1];
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign resp_valid = vld_q[RD_LAT-1];
  assign resp_err   = err_q[RD_LAT-1];
  assign resp_rdata = dat_q[RD_LAT-1];

endmodule

// File: tb/tb_dmem_pipe_ctrl.sv
// Directed bench: two controllers (RD_LAT 1 and 3) share one stimulus
// stream; each step checks responses against hand-computed values.
module tb_dmem_pipe_ctrl;

  logic        clock, reset;
  logic        req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;

  logic        rdy1, rv1, er1, dn1;
  logic [31:0] rd1;
  logic        rdy3, rv3, er3, dn3;
  logic [31:0] rd3;

  int errors = 0;
  int checks = 0;
  int bad;
  logic [31:0] vals [8] = '{32'd8, 32'd9, 32'd7, 32'd10,
                            32'd6, 32'd4, 32'd14, 32'd5};
  logic [31:0] exp3;

  dmem_pipe_ctrl #(.RD_LAT(1)) u1 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(rdy1),
    .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rd1),
    .resp_err(er1), .init_done(dn1)
  );

  dmem_pipe_ctrl #(.RD_LAT(3)) u3 (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(rdy3),
    .req_we(req_we), .req_addr(req_addr),
    .req_be(req_be), .req_wdata(req_wdata),
    .resp_valid(rv3), .resp_rdata(rd3),
    .resp_err(er3), .init_done(dn3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_be    = be;
    req_wdata = wd;
  endtask

  task automatic idle;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_be    = '0;
    req_wdata = '0;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    repeat (2) tick();
    chk("rst_ready", {31'd0, rdy1}, 32'd0);
    chk("rst_rvalid", {31'd0, rv1}, 32'd0);
    chk("rst_rdata", rd1, 32'd0);
    chk("rst_err", {31'd0, er1}, 32'd0);
    chk("rst_done", {31'd0, dn1}, 32'd0);

    reset = 1'b0;
    repeat (255) tick();
    chk("init_ready1", {31'd0, rdy1}, 32'd0);
    chk("init_ready3", {31'd0, rdy3}, 32'd0);
    chk("init_done1", {31'd0, dn1}, 32'd0);
    tick();
    chk("run_ready1", {31'd0, rdy1}, 32'd1);
    chk("run_done1", {31'd0, dn1}, 32'd1);
    chk("run_ready3", {31'd0, rdy3}, 32'd1);

    drive(1'b0, 32'h0, 4'h0, 32'h0); tick();
    chk("init_w0_v", {31'd0, rv1}, 32'd1);
    chk("init_w0", rd1, 32'h0);
    drive(1'b0, 32'h44, 4'h0, 32'h0); tick();
    chk("init_w17", rd1, 32'h0);
    drive(1'b0, 32'h3FC, 4'h0, 32'h0); tick();
    chk("init_w255", rd1, 32'h0);
    chk("init_w255_e", {31'd0, er1}, 32'd0);
    idle(); tick();
    chk("idle_v", {31'd0, rv1}, 32'd0);
    chk("idle_d", rd1, 32'd0);

    drive(1'b1, 32'h10, 4'hF, 32'hDEADBEEF); tick();
    chk("wr_v", {31'd0, rv1}, 32'd1);
    chk("wr_d", rd1, 32'd0);
    chk("wr_e", {31'd0, er1}, 32'd0);
    drive(1'b0, 32'h10, 4'h0, 32'h0); tick();
    chk("rd_v", {31'd0, rv1}, 32'd1);
    chk("rd_d", rd1, 32'hDEADBEEF);
    idle(); tick();

    drive(1'b1, 32'h20, 4'hF, 32'h11223344); tick();
    drive(1'b1, 32'h20, 4'b0101, 32'hAABBCCDD); tick();
    drive(1'b0, 32'h20, 4'h0, 32'h0); tick();
    chk("be_d", rd1, 32'h11BB33DD);

    drive(1'b0, 32'h22, 4'h0, 32'h0); tick();
    chk("mis_v", {31'd0, rv1}, 32'd1);
    chk("mis_e", {31'd0, er1}, 32'd1);
    chk("mis_d", rd1, 32'd0);
    drive(1'b1, 32'h400, 4'hF, 32'hFFFFFFFF); tick();
    chk("oor_e", {31'd0, er1}, 32'd1);
    chk("oor_d", rd1, 32'd0);
    drive(1'b0, 32'h0, 4'h0, 32'h0); tick();
    chk("oor_w0_d", rd1, 32'h0);
    chk("oor_w0_e", {31'd0, er1}, 32'd0);
    drive(1'b1, 32'h10, 4'h0, 32'h12345678); tick();
    chk("be0_v", {31'd0, rv1}, 32'd1);
    drive(1'b0, 32'h10, 4'h0, 32'h0); tick();
    chk("be0_d", rd1, 32'hDEADBEEF);

    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'(i * 4), 4'hF, vals[i]);
      tick();
    end
    idle();
    repeat (3) tick();

    for (int t = 0; t < 11; t++) begin
      if (t < 8) drive(1'b0, 32'(t * 4), 4'h0, 32'h0);
      else idle();
      tick();
      exp3 = (t >= 2 && t <= 9) ? vals[t-2] : 32'd0;
      chk($sformatf("pipe_v%0d", t), {31'd0, rv3},
          {31'd0, (t >= 2 && t <= 9)});
      chk($sformatf("pipe_d%0d", t), rd3, exp3);
      if (t < 8) chk($sformatf("lat1_d%0d", t), rd1, vals[t]);
    end

    drive(1'b0, 32'h0, 4'h0, 32'h0); tick();
    drive(1'b0, 32'h4, 4'h0, 32'h0); tick();
    idle(); tick();
    chk("mid_v", {31'd0, rv3}, 32'd1);
    chk("mid_d", rd3, 32'd8);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_v", {31'd0, rv3}, 32'd0);
    chk("mid_rst_rdy", {31'd0, rdy3}, 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b0, 32'h4, 4'h0, 32'h0);
    bad = 0;
    for (int i = 0; i < 255; i++) begin
      tick();
      if (rv3 || rdy3 || rv1 || rdy1) bad++;
    end
    chk("reinit_quiet", 32'(bad), 32'd0);
    tick();
    chk("reinit_rdy3", {31'd0, rdy3}, 32'd1);
    chk("reinit_v3", {31'd0, rv3}, 32'd0);
    idle(); tick();
    chk("reinit_v3b", {31'd0, rv3}, 32'd0);
    chk("reinit_v1", {31'd0, rv1}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_pipe_ctrl.md
Name: dmem_pipe_ctrl

Overview:
- Parametrised synchronous data memory for the next-generation (pipelined/multi-cycle) MIPS core. It replaces the behavioural, combinational-read data memory.
- Adds the following over that memory: ready/valid request handshake, configurable read latency, byte-lane write enables, alignment and range error reporting, and a hardware init sweep after reset.
- One request per cycle is accepted. Each accepted request returns exactly one in-order response.

Parameters:
- DATA_W, 32, data word width in bits; multiple of 8, at least 8.
- DEPTH, 256, number of words; at least 2.
- ADDR_W, 32, byte-address width of req_addr.
- RD_LAT, 1, request-to-response latency in cycles; legal range 1..4.
- INIT_VAL, 0, value written to every word by the init sweep.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  byte address.
- req_be  in  DATA_W/8  byte-lane write enables; ignored for reads.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response strobe, one cycle per accepted request.
- resp_rdata  out  DATA_W  read data; 0 for writes and for errored requests.
- resp_err  out  1  request was misaligned or out of range.
- init_done  out  1  init sweep complete.

Behaviour:
- Reset values (asynchronous): req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_done=0, state=INIT, init_ptr=0, latency pipeline cleared.
- Definitions:
  - B = log2(DATA_W/8).
  - Word index = req_addr >> B.
  - Misaligned if req_addr[B-1:0] != 0 (never misaligned when DATA_W=8).
  - Out of range if word index >= DEPTH.
  - Error = misaligned OR out of range.
- State INIT:
  - Each cycle writes INIT_VAL to mem[init_ptr] and increments init_ptr.
  - After writing word DEPTH-1, go to RUN on the next edge. INIT therefore lasts exactly DEPTH cycles after reset deasserts.
  - req_ready=0 throughout INIT.
- State RUN:
  - req_ready=1 and init_done=1 continuously.
  - No backpressure exists on the response side.
  - Only reset leaves RUN.
- Accept: a request is accepted on a rising edge where req_valid && req_ready.
- Write:
  - Performed at the accept edge.
  - For each lane i with req_be[i]=1, mem[idx][8i+7:8i] <= req_wdata[8i+7:8i]. Other lanes are unchanged.
  - If error: memory is not modified.
- Read:
  - Data is sampled from the array at the accept edge.
  - A write accepted at edge N is visible to a read accepted at edge N+1 or later.
- Response timing:
  - A request accepted at edge N drives resp_valid=1 during the cycle following edge N+RD_LAT-1. With RD_LAT=1, the response is visible in the cycle right after acceptance.
  - The data and err for that request are carried through an RD_LAT-deep shift pipeline.
- Throughput and ordering: back-to-back requests give back-to-back responses, in order, with no bubbles.
- Response content:
  - Read: resp_rdata = word.
  - Write: resp_rdata = 0.
  - Error: resp_err=1 and resp_rdata=0.
  - When resp_valid=0: resp_rdata=0 and resp_err=0.
- req_be=0 on a write: legal. Memory is unchanged and resp_valid is still produced.
- Reset mid-operation: in-flight responses are discarded (resp_valid drops immediately). Memory contents are undefined until the new INIT sweep completes, and INIT restarts from word 0.
- req_valid during INIT: ignored, not queued. The requester must hold req_valid until req_ready is 1.
- Parameter check: RD_LAT outside 1..4 or DATA_W not a multiple of 8 triggers an elaboration-time $error.

Test Plan:
- Init sweep: reset for 1 cycle, then deassert -> req_ready=0 for exactly 256 cycles, then req_ready=1 and init_done=1. Reading word indices 0, 17 and 255 returns 0x00000000.
- Write/read, RD_LAT=1:
  - Write 0xDEADBEEF to addr 0x10 with be=4'hF, then read 0x10 on the next cycle.
  - Expect resp_valid for the write (rdata=0), then resp_rdata=0xDEADBEEF exactly 1 cycle after the read is accepted.
- Byte enables:
  - Write 0x11223344 to addr 0x20 with be=4'hF.
  - Then write 0xAABBCCDD to addr 0x20 with be=4'b0101.
  - Read addr 0x20 -> 0x11BB33DD.
- Errors:
  - Read addr 0x22 (misaligned) -> resp_err=1, rdata=0.
  - Write addr 0x400 (index 256) -> resp_err=1. A subsequent read of word 0 is unchanged.
- Pipelining, RD_LAT=3:
  - Issue 8 back-to-back reads of words 0..7 preloaded with 8,9,7,10,6,4,14,5.
  - Expect 8 consecutive resp_valid cycles starting 3 cycles after the first accept, data in that order.
- Reset mid-flight, RD_LAT=3:
  - Assert reset asynchronously 1 cycle after 2 reads are accepted.
  - resp_valid=0 immediately and stays 0, and no stale responses appear after reset.
  - req_ready returns only after 256 INIT cycles.
